cam_capture: RTL

//  Synthesizable receiver for the parallel camera interface (pixel/vsync/hsync).

---
 rtl/cam_pkg.sv | 20 ++
 rtl/cam_nibble_pack.sv | 42 ++++
 rtl/cam_capture.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared types for the camera capture block: FSM state encoding and the frame summary record.
package cam_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        IDLE  = 2'd1,
        FRAME = 2'd2
    } cam_state_t;

    localparam int CAM_INFO_W = 16;

    // Frame geometry/error summary, sized for the largest supported sensor.
    typedef struct packed {
        logic [CAM_INFO_W-1:0] cols;
        logic [CAM_INFO_W-1:0] rows;
        logic                  err_line_len;
        logic                  err_nibble;
    } cam_frame_info_t;

endpackage

// File: rtl/cam_nibble_pack.sv
// Joins two consecutive half-width nibbles (MS nibble first) into one pixel.
module cam_nibble_pack
    import cam_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vld,
    input  logic [WIDTH/2-1:0] nib,
    input  logic               line_clr,
    output logic               out_vld,
    output logic [WIDTH-1:0]   out_pix,
    output logic               odd_err
);

    logic               phase_r;
    logic [WIDTH/2-1:0] hold_r;

    // Phase flop and MS-nibble holding register; a line boundary realigns the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= 1'b0;
            hold_r  <= {(WIDTH/2){1'b0}};
        end else if (line_clr) begin
            phase_r <= 1'b0;
        end else if (in_vld) begin
            phase_r <= ~phase_r;
            if (!phase_r) begin
                hold_r <= nib;
            end
        end
    end

    // A pixel completes on the second nibble; a boundary while half-full is an error.
    always_comb begin
        out_vld = in_vld & phase_r;
        out_pix = {hold_r, nib};
        odd_err = line_clr & phase_r;
    end

endmodule

// File: rtl/cam_capture.sv
// Parallel camera receiver: samples pixel/vsync/hsync, packs nibbles, measures frame geometry.
// Optional window cropping is enabled by defining CAM_CAPTURE_CROP_EN.
module cam_capture
    import cam_pkg::*;
#(
    parameter string FOUR_BITS = "FALSE",
    parameter int    WIDTH     = 8,
    parameter int    MAX_COLS  = 1000,
    parameter int    MAX_ROWS  = 1000,
    parameter int    COL_W     = $clog2(MAX_COLS + 1),
    parameter int    ROW_W     = $clog2(MAX_ROWS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] cam_pixel,
    input  logic             cam_vsync,
    input  logic             cam_hsync,
`ifdef CAM_CAPTURE_CROP_EN
    input  logic [COL_W-1:0] crop_x0,
    input  logic [COL_W-1:0] crop_x1,
    input  logic [ROW_W-1:0] crop_y0,
    input  logic [ROW_W-1:0] crop_y1,
`endif
    output logic [WIDTH-1:0] pix_data,
    output logic             pix_valid,
    output logic             pix_sof,
    output logic             line_end,
    output logic             frame_end,
    output logic [COL_W-1:0] frame_cols,
    output logic [ROW_W-1:0] frame_rows,
    output logic             err_line_len,
    output logic             err_nibble,
    output logic             busy
);

    localparam logic [COL_W-1:0] MAX_C = COL_W'(MAX_COLS);
    localparam logic [ROW_W-1:0] MAX_R = ROW_W'(MAX_ROWS);

    cam_state_t       state_r, state_nxt_s;
    logic [WIDTH-1:0] s_pix_r;
    logic             s_vs_r, s_hs_r, vs_d_r, hs_d_r;
    logic             vs_rise_s, vs_fall_s, hs_fall_s, in_frame_s, accept_s, start_s;
    logic             pk_vld_s, odd_err_s;
    logic [WIDTH-1:0] pk_pix_s;
    logic [COL_W-1:0] col_cnt_r, frame_cols_r;
    logic [ROW_W-1:0] row_cnt_r, rows_nxt_s, frame_rows_r;
    logic             first_line_r, sof_pend_r;
    logic             col_full_s, emit_s, drop_s, line_done_s, len_bad_s;
    logic             col_win_s, row_win_s, out_vld_s;
    logic [WIDTH-1:0] pix_data_r;
    logic             pix_valid_r, pix_sof_r, line_end_r, frame_end_r;
    logic             err_len_r, err_nib_r, busy_r;
`ifdef CAM_CAPTURE_CROP_EN
    logic [COL_W-1:0] x0_r, x1_r;
    logic [ROW_W-1:0] y0_r, y1_r;
`endif

    // Input stage; vsync copies reset high so a frame already in progress is never seen as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_pix_r <= {WIDTH{1'b0}};
            s_vs_r  <= 1'b1;
            vs_d_r  <= 1'b1;
            s_hs_r  <= 1'b0;
            hs_d_r  <= 1'b0;
        end else begin
            s_pix_r <= cam_pixel;
            s_vs_r  <= cam_vsync;
            vs_d_r  <= s_vs_r;
            s_hs_r  <= cam_hsync;
            hs_d_r  <= s_hs_r;
        end
    end

    // Edge detection and frame-state next-state logic.
    always_comb begin
        vs_rise_s   = s_vs_r & ~vs_d_r;
        vs_fall_s   = ~s_vs_r & vs_d_r;
        hs_fall_s   = ~s_hs_r & hs_d_r;
        in_frame_s  = (state_r == FRAME);
        accept_s    = in_frame_s & s_vs_r & s_hs_r;
        start_s     = (state_r == IDLE) & vs_rise_s & enable;
        state_nxt_s = state_r;
        case (state_r)
            SYNC:    if (!s_vs_r) state_nxt_s = IDLE; else state_nxt_s = SYNC;
            IDLE:    if (vs_rise_s) state_nxt_s = enable ? FRAME : SYNC; else state_nxt_s = IDLE;
            FRAME:   if (vs_fall_s) state_nxt_s = IDLE; else state_nxt_s = FRAME;
            default: state_nxt_s = SYNC;
        endcase
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SYNC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    generate
        if (FOUR_BITS == "TRUE") begin : g_four
            cam_nibble_pack #(.WIDTH(WIDTH)) u_pack (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_vld   (accept_s),
                .nib      (s_pix_r[WIDTH/2-1:0]),
                .line_clr (hs_fall_s | vs_fall_s),
                .out_vld  (pk_vld_s),
                .out_pix  (pk_pix_s),
                .odd_err  (odd_err_s)
            );
        end else begin : g_eight
            assign pk_vld_s  = accept_s;
            assign pk_pix_s  = s_pix_r;
            assign odd_err_s = 1'b0;
        end
    endgenerate

    // Pixel accounting, line length checking and output window gating.
    always_comb begin
        col_full_s  = (col_cnt_r == MAX_C);
        emit_s      = pk_vld_s & ~col_full_s;
        drop_s      = pk_vld_s & col_full_s;
        line_done_s = in_frame_s & hs_fall_s & (col_cnt_r != {COL_W{1'b0}});
        len_bad_s   = line_done_s & ~first_line_r & (col_cnt_r != frame_cols_r);
        if (line_done_s && (row_cnt_r != MAX_R)) begin
            rows_nxt_s = row_cnt_r + ROW_W'(1);
        end else begin
            rows_nxt_s = row_cnt_r;
        end
`ifdef CAM_CAPTURE_CROP_EN
        col_win_s = (col_cnt_r >= x0_r) && (col_cnt_r <= x1_r);
        row_win_s = (row_cnt_r >= y0_r) && (row_cnt_r <= y1_r);
`else
        col_win_s = 1'b1;
        row_win_s = 1'b1;
`endif
        out_vld_s = emit_s & col_win_s & row_win_s;
    end

    // Column/row counters and line-0 geometry capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_r    <= {COL_W{1'b0}};
            row_cnt_r    <= {ROW_W{1'b0}};
            frame_cols_r <= {COL_W{1'b0}};
            first_line_r <= 1'b1;
        end else if (start_s) begin
            col_cnt_r    <= {COL_W{1'b0}};
            row_cnt_r    <= {ROW_W{1'b0}};
            first_line_r <= 1'b1;
        end else begin
            if (hs_fall_s) begin
                col_cnt_r <= {COL_W{1'b0}};
            end else if (emit_s) begin
                col_cnt_r <= col_cnt_r + COL_W'(1);
            end
            row_cnt_r <= rows_nxt_s;
            if (line_done_s) begin
                first_line_r <= 1'b0;
            end
            if (line_done_s && first_line_r) begin
                frame_cols_r <= col_cnt_r;
            end
        end
    end

`ifdef CAM_CAPTURE_CROP_EN
    // Crop window is frozen for the whole frame at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_r <= {COL_W{1'b0}};
            x1_r <= {COL_W{1'b0}};
            y0_r <= {ROW_W{1'b0}};
            y1_r <= {ROW_W{1'b0}};
        end else if (start_s) begin
            x0_r <= crop_x0;
            x1_r <= crop_x1;
            y0_r <= crop_y0;
            y1_r <= crop_y1;
        end
    end
`endif

    // Registered stream outputs, markers and sticky error flags (cleared by the next start of frame).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_data_r   <= {WIDTH{1'b0}};
            pix_valid_r  <= 1'b0;
            pix_sof_r    <= 1'b0;
            line_end_r   <= 1'b0;
            frame_end_r  <= 1'b0;
            frame_rows_r <= {ROW_W{1'b0}};
            err_len_r    <= 1'b0;
            err_nib_r    <= 1'b0;
            sof_pend_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            if (out_vld_s) begin
                pix_data_r <= pk_pix_s;
            end
            pix_valid_r <= out_vld_s;
            pix_sof_r   <= out_vld_s & sof_pend_r;
            line_end_r  <= line_done_s & row_win_s;
            frame_end_r <= in_frame_s & vs_fall_s;
            busy_r      <= (state_nxt_s == FRAME);
            if (in_frame_s && vs_fall_s) begin
                frame_rows_r <= rows_nxt_s;
            end
            if (start_s) begin
                sof_pend_r <= 1'b1;
            end else if (out_vld_s) begin
                sof_pend_r <= 1'b0;
            end
            if (out_vld_s && sof_pend_r) begin
                err_len_r <= 1'b0;
                err_nib_r <= 1'b0;
            end else begin
                if (drop_s || len_bad_s) err_len_r <= 1'b1;
                if (in_frame_s && odd_err_s) err_nib_r <= 1'b1;
            end
        end
    end

    assign pix_data     = pix_data_r;
    assign pix_valid    = pix_valid_r;
    assign pix_sof      = pix_sof_r;
    assign line_end     = line_end_r;
    assign frame_end    = frame_end_r;
    assign frame_cols   = frame_cols_r;
    assign frame_rows   = frame_rows_r;
    assign err_line_len = err_len_r;
    assign err_nibble   = err_nib_r;
    assign busy         = busy_r;

endmodule
